// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB LED arbiter.
package rgb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_e;

    // Colour encodings {r,g,b}; 1 = channel lit.
    localparam logic [2:0] C_OFF   = 3'b000;
    localparam logic [2:0] C_RED   = 3'b100;
    localparam logic [2:0] C_GREEN = 3'b010;
    localparam logic [2:0] C_BLUE  = 3'b001;
    localparam logic [2:0] C_WHITE = 3'b111;

    // One-hot grant vector for a requester index.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rgb_pwm_dimmer.sv
// PWM dimmer with registered active-low LED pins.
// A channel is lit while en is high, its colour bit is set and pwm_cnt < duty.
module rgb_pwm_dimmer
    import rgb_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [2:0]          col,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led_red,
    output logic                led_green,
    output logic                led_blue
);

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [2:0]          pins_q, pins_d;
    logic [2:0]          lit;

    // Free-running PWM counter and the active-low pin value for the next cycle.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        lit       = C_OFF;
        if (en && (pwm_cnt_q < duty)) begin
            lit = col;
        end
        pins_d = ~lit;
    end

    // Pin stage; reset forces all pins high (off) without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            pins_q    <= 3'b111;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            pins_q    <= pins_d;
        end
    end

    assign led_red   = pins_q[2];
    assign led_green = pins_q[1];
    assign led_blue  = pins_q[0];

endmodule

// File: rtl/rgb_led_arbiter.sv
// Round-robin arbiter sharing one active-low RGB LED between two requesters.
// A grant holds the LED for HOLD_TICKS ticks, then a blank GAP of up to one tick
// separates owners. rst_n is asserted asynchronously and is expected to be
// released synchronously to clk by the board-level reset logic.
module rgb_led_arbiter
    import rgb_pkg::*;
#(
    parameter int TICK_DIV   = 12000,
    parameter int HOLD_TICKS = 500,
    parameter int PWM_BITS   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    input  logic [2:0]          color0,
    input  logic [2:0]          color1,
    input  logic [PWM_BITS-1:0] duty,
    output logic [1:0]          gnt,
    output logic                busy,
    output logic                led_red,
    output logic                led_green,
    output logic                led_blue,
    output logic [1:0]          dbg_state
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    state_e            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              owner_q, owner_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [2:0]        col_q, col_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              winner;

    // Free-running tick divider; never restarted by a grant.
    always_comb begin
        tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    end

    // Next-state logic for arbitration, hold timing and the blank gap.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        col_d      = col_q;
        hold_cnt_d = hold_cnt_q;
        winner     = req[1];
        case (state_q)
            IDLE: begin
                if (req == 2'b11) begin
                    winner = rr_ptr_q;
                end
                if (|req) begin
                    owner_d    = winner;
                    gnt_d      = onehot2(winner);
                    col_d      = winner ? color1 : color0;
                    hold_cnt_d = '0;
                    state_d    = SHOW;
                end
            end
            SHOW: begin
                // Owner withdrawing its request aborts the grant immediately.
                if (!req[owner_q]) begin
                    state_d  = GAP;
                    gnt_d    = 2'b00;
                    rr_ptr_d = ~owner_q;
                end else if (tick) begin
                    if (hold_cnt_q == HOLD_W'(HOLD_TICKS - 1)) begin
                        state_d  = GAP;
                        gnt_d    = 2'b00;
                        rr_ptr_d = ~owner_q;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
            end
            GAP: begin
                gnt_d = 2'b00;
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // FSM, grant and round-robin state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            owner_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            col_q      <= C_OFF;
            hold_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            col_q      <= col_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    rgb_pwm_dimmer #(
        .PWM_BITS (PWM_BITS)
    ) u_dimmer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state_q == SHOW),
        .col       (col_q),
        .duty      (duty),
        .led_red   (led_red),
        .led_green (led_green),
        .led_blue  (led_blue)
    );

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed bench for rgb_led_arbiter with TICK_DIV=4, HOLD_TICKS=3, PWM_BITS=4.
// After reset release, edge Ek leaves tick_cnt=k%4 and pwm_cnt=k%16; ticks are
// sampled at E4, E8, E12, ...; pins after Ek reflect state/pwm after E(k-1).
module tb_rgb_led_arbiter;
    import rgb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [2:0] color0 = C_OFF;
    logic [2:0] color1 = C_OFF;
    logic [3:0] duty = 4'd0;
    logic [1:0] gnt;
    logic       busy;
    logic       led_red, led_green, led_blue;
    logic [1:0] dbg_state;
    logic [2:0] leds;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    assign leds = {led_red, led_green, led_blue};

    rgb_led_arbiter #(
        .TICK_DIV   (4),
        .HOLD_TICKS (3),
        .PWM_BITS   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .color0    (color0),
        .color1    (color1),
        .duty      (duty),
        .gnt       (gnt),
        .busy      (busy),
        .led_red   (led_red),
        .led_green (led_green),
        .led_blue  (led_blue),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock edge and sample at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic go_to(input int k);
        while (cyc < k) step();
    endtask

    // Reset with inputs applied; checks reset state while held; releases at a falling edge.
    task automatic do_reset(input logic [1:0] r, input logic [2:0] c0, input logic [2:0] c1,
                            input logic [3:0] d);
        @(negedge clk);
        rst_n  = 1'b0;
        req    = r;
        color0 = c0;
        color1 = c1;
        duty   = d;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_gnt", gnt, 2'b00);
            check_eq("rst_busy", busy, 1'b0);
            check_eq("rst_leds", leds, 3'b111);
            check_eq("rst_state", dbg_state, IDLE);
        end
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        int lit_cnt;
        logic [1:0] exp_gnt;
        logic [3:0] duty_tab [3];
        int         lit_tab  [3];
        duty_tab = '{4'd0, 4'd4, 4'd15};
        lit_tab  = '{0, 4, 10};

        // Reset with both requesting, then single requester on green.
        do_reset(2'b11, C_GREEN, C_OFF, 4'd15);
        do_reset(2'b01, C_GREEN, C_OFF, 4'd15);
        step();
        check_eq("t2_gnt_e1", gnt, 2'b01);
        check_eq("t2_busy_e1", busy, 1'b1);
        check_eq("t2_leds_e1", leds, 3'b111);
        for (int k = 2; k <= 11; k++) begin
            step();
            check_eq("t2_gnt_show", gnt, 2'b01);
            check_eq("t2_leds_show", leds, 3'b101);
        end
        step();
        check_eq("t2_gnt_e12", gnt, 2'b00);
        check_eq("t2_busy_e12", busy, 1'b1);
        check_eq("t2_leds_e12", leds, 3'b101);
        req = 2'b00;
        step();
        check_eq("t2_leds_gap", leds, 3'b111);
        check_eq("t2_state_gap", dbg_state, GAP);
        go_to(15);
        check_eq("t2_busy_e15", busy, 1'b1);
        step();
        check_eq("t2_busy_e16", busy, 1'b0);
        check_eq("t2_state_e16", dbg_state, IDLE);

        // Contention: grants alternate with a gap between them.
        do_reset(2'b11, C_RED, C_BLUE, 4'd15);
        for (int k = 1; k <= 34; k++) begin
            step();
            if (k <= 11) exp_gnt = 2'b01;
            else if (k >= 17 && k <= 27) exp_gnt = 2'b10;
            else if (k >= 33) exp_gnt = 2'b01;
            else exp_gnt = 2'b00;
            check_eq("t3_gnt", gnt, exp_gnt);
            check_eq("t3_onehot0", $onehot0(gnt), 1'b1);
            if (k == 2)  check_eq("t3_leds_red", leds, 3'b011);
            if (k == 13) check_eq("t3_leds_gap", leds, 3'b111);
            if (k == 18) check_eq("t3_leds_blue", leds, 3'b110);
        end

        // Abort: owner 0 drops mid-SHOW while requester 1 asks.
        do_reset(2'b01, C_GREEN, C_RED, 4'd15);
        go_to(5);
        check_eq("t4_gnt_pre", gnt, 2'b01);
        req = 2'b10;
        step();
        check_eq("t4_gnt_abort", gnt, 2'b00);
        check_eq("t4_busy_abort", busy, 1'b1);
        check_eq("t4_leds_abort", leds, 3'b101);
        step();
        check_eq("t4_leds_off", leds, 3'b111);
        step();
        check_eq("t4_idle", busy, 1'b0);
        step();
        check_eq("t4_gnt_other", gnt, 2'b10);
        step();
        check_eq("t4_leds_other", leds, 3'b011);
        go_to(11);
        check_eq("t6_leds_pre", leds, 3'b011);

        // Async reset mid-SHOW: outputs clear without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_leds_async", leds, 3'b111);
        check_eq("t6_gnt_async", gnt, 2'b00);
        check_eq("t6_busy_async", busy, 1'b0);
        do_reset(2'b11, C_RED, C_BLUE, 4'd15);
        step();
        check_eq("t6_rr_ptr0", gnt, 2'b01);

        // Duty sweep: SHOW spans pins after E14..E24, i.e. pwm 13,14,15,0..7.
        for (int i = 0; i < 3; i++) begin
            do_reset(2'b00, C_GREEN, C_OFF, duty_tab[i]);
            go_to(12);
            req = 2'b01;
            step();
            check_eq("t5_gnt", gnt, 2'b01);
            lit_cnt = 0;
            for (int k = 14; k <= 24; k++) begin
                step();
                if (leds == 3'b101) lit_cnt++;
                else check_eq("t5_leds_offval", leds, 3'b111);
            end
            check_eq("t5_lit_cnt", lit_cnt, lit_tab[i]);
            step();
            check_eq("t5_leds_gap", leds, 3'b111);
            req = 2'b00;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
